// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV64M multiply/divide sequencer (shift-add mul, restoring div).
// Define MDU_FAST_MUL_EN to compute every multiply in one cycle with a 128-bit '*'.
module mdu_seq #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic            is_word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t       state_q, state_d;
   logic [6:0]   cnt_q, cnt_d;
   logic [127:0] acc_q, acc_d;
   logic [63:0]  b_q, b_d;
   logic         neg_q, neg_d;
   logic         word_q, word_d;
   logic         div_q, div_d;
   logic         rem_q, rem_d;
   logic         hi_q, hi_d;
   logic [63:0]  result_q, result_d;

   logic         is_mul, s1, s2, n1, n2, dz, ovf, neg_in, hi_in;
   logic [63:0]  x1, x2, m1, m2, sp_res;
   logic [64:0]  sum, trial, diff;
   logic [127:0] nxt;
   logic [63:0]  fin;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] mul_fix(input logic [127:0] p,
                                           input logic neg,
                                           input logic word,
                                           input logic hi);
      logic [127:0] s;
      s = neg ? -p : p;
      if (word) return sext32(s[31:0]);
      return hi ? s[127:64] : s[63:0];
   endfunction

   function automatic logic [63:0] div_fix(input logic [63:0] v,
                                           input logic neg,
                                           input logic word);
      logic [63:0] s;
      s = neg ? -v : v;
      return word ? sext32(s[31:0]) : s;
   endfunction

   // Decode op, prepare operand magnitudes and detect divide special cases.
   always_comb begin
      is_mul = ~op[2];
      s1     = is_mul ? (is_word | (op[1:0] != 2'b11)) : ~op[0];
      s2     = is_mul ? (is_word | ~op[1]) : ~op[0];
      x1     = is_word ? (s1 ? sext32(src1[31:0]) : {32'd0, src1[31:0]}) : src1;
      x2     = is_word ? (s2 ? sext32(src2[31:0]) : {32'd0, src2[31:0]}) : src2;
      n1     = s1 & x1[63];
      n2     = s2 & x2[63];
      m1     = n1 ? -x1 : x1;
      m2     = n2 ? -x2 : x2;
      hi_in  = ~is_word & (op[1:0] != 2'b00);
      neg_in = (is_mul | ~op[1]) ? (n1 ^ n2) : n1;
      dz     = ~is_mul & (x2 == 64'd0);
      ovf    = ~is_mul & ~op[0] & (x2 == '1) &
               (x1 == (is_word ? 64'hFFFF_FFFF_8000_0000
                               : 64'h8000_0000_0000_0000));
      if (dz) sp_res = op[1] ? (is_word ? sext32(src1[31:0]) : src1) : '1;
      else    sp_res = op[1] ? 64'd0 : x1;
   end

   // One shift-add or restoring-divide step, plus the sign fix-up of that step.
   always_comb begin
      sum   = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, b_q} : 65'd0);
      trial = {acc_q[127:64], acc_q[63]};
      diff  = trial - {1'b0, b_q};
      if (div_q)
         nxt = {diff[64] ? trial[63:0] : diff[63:0], acc_q[62:0], ~diff[64]};
      else
         nxt = {sum, acc_q[63:1]};
      if (div_q)
         fin = div_fix(rem_q ? nxt[127:64] : nxt[63:0], neg_q, word_q);
      else
         fin = mul_fix(word_q ? {32'd0, nxt[127:32]} : nxt, neg_q, word_q, hi_q);
   end

   // Next-state logic; flush overrides everything and leaves result untouched.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      b_d      = b_q;
      neg_d    = neg_q;
      word_d   = word_q;
      div_d    = div_q;
      rem_d    = rem_q;
      hi_d     = hi_q;
      result_d = result_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (in_valid) begin
               cnt_d  = 7'd0;
               neg_d  = neg_in;
               word_d = is_word;
               div_d  = ~is_mul;
               rem_d  = op[1];
               hi_d   = hi_in;
               b_d    = is_mul ? m1 : m2;
               acc_d  = is_mul  ? {64'd0, m2} :
                        is_word ? {64'd0, m1[31:0], 32'd0} : {64'd0, m1};
               if (dz | ovf) begin
                  result_d = sp_res;
                  state_d  = DONE;
               end
`ifdef MDU_FAST_MUL_EN
               else if (is_mul) begin
                  result_d = mul_fix({64'd0, m1} * {64'd0, m2},
                                     neg_in, is_word, hi_in);
                  state_d  = DONE;
               end
`endif
               else begin
                  state_d = CALC;
               end
            end
            CALC: begin
               acc_d = nxt;
               cnt_d = cnt_q + 7'd1;
               if (cnt_q == (word_q ? 7'd31 : 7'd63)) begin
                  result_d = fin;
                  state_d  = DONE;
               end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         word_q   <= 1'b0;
         div_q    <= 1'b0;
         rem_q    <= 1'b0;
         hi_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         word_q   <= word_d;
         div_q    <= div_d;
         rem_q    <= rem_d;
         hi_q     <= hi_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == IDLE) & ~flush;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: vector table, corner sequences and random ops for mdu_seq.
// Expected values come from plain-arithmetic RV64M semantics.
module tb_mdu_seq;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, is_word, flush;
   logic        out_valid, out_ready, busy;
   logic [2:0]  op;
   logic [63:0] src1, src2, result;
   int          checks = 0;
   int          errors = 0;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT64 = 1;
   localparam int MUL_LAT32 = 1;
`else
   localparam int MUL_LAT64 = 65;
   localparam int MUL_LAT32 = 33;
`endif

   typedef struct {
      logic [2:0]  op;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] r;
      int          lat;
   } vec_t;

   mdu_seq #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .is_word(is_word), .src1(src1), .src2(src2),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                         input logic [63:0] a,
                                         input logic [63:0] b);
      logic [127:0]       p;
      logic signed [63:0] sa, sb;
      logic signed [31:0] wa, wb;
      logic [31:0]        ua, ub, t;
      ua = a[31:0]; ub = b[31:0];
      wa = ua;      wb = ub;
      sa = a;       sb = b;
      if (w) begin
         case (o)
            3'd4: begin
               if (ub == 0) return '1;
               if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx(ua);
               t = wa / wb; return sx(t);
            end
            3'd5: begin
               if (ub == 0) return '1;
               t = ua / ub; return sx(t);
            end
            3'd6: begin
               if (ub == 0) return sx(ua);
               if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return 0;
               t = wa % wb; return sx(t);
            end
            3'd7: begin
               if (ub == 0) return sx(ua);
               t = ua % ub; return sx(t);
            end
            default: begin
               t = ua * ub; return sx(t);
            end
         endcase
      end
      case (o)
         3'd0: return a * b;
         3'd1: begin
            p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64];
         end
         3'd2: begin
            p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64];
         end
         3'd3: begin
            p = {64'd0, a} * {64'd0, b}; return p[127:64];
         end
         3'd4: begin
            if (b == 0) return '1;
            if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
            return sa / sb;
         end
         3'd5: return (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 64'h8000_0000_0000_0000 && b == '1) return 0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] o, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      if (!o[2]) return w ? MUL_LAT32 : MUL_LAT64;
      if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
      if (!o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                      : (a == 64'h8000_0000_0000_0000 && b == '1))) return 1;
      return w ? 33 : 65;
   endfunction

   function automatic logic [63:0] rnd();
      logic [63:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 8))
         0: return v;
         1: return 64'($urandom_range(0, 40));
         2: return 64'd0;
         3: return '1;
         4: return 64'h8000_0000_0000_0000;
         5: return 64'd0 - 64'($urandom_range(1, 40));
         6: begin v[31:0] = 32'h8000_0000; return v; end
         7: begin v[31:0] = 32'hFFFF_FFFF; return v; end
         default: begin v[31:0] = 32'd0; return v; end
      endcase
   endfunction

   task automatic do_op(input string name, input logic [2:0] o, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input int el);
      int lat;
      chk({name, " in_ready"}, 64'(in_ready), 64'd1);
      op = o; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = ~o; src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, " latency"}, 64'(lat), 64'(el));
      chk({name, " result"}, result, er);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, " release"}, {62'd0, out_valid, ~in_ready}, 64'd0);
   endtask

   vec_t        tbl [16];
   logic [63:0] prev;
   logic [2:0]  ro;
   logic        rw, seen;
   logic [63:0] ra, rb;
   int          n;

   initial begin
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      op = 3'd0; is_word = 1'b0; src1 = '0; src2 = '0;
      #2 rst = 1'b1;
      #2;
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset result", result, 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      tbl[0]  = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};
      tbl[1]  = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65};
      tbl[2]  = '{3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
      tbl[3]  = '{3'd6, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
      tbl[4]  = '{3'd4, 1'b0, 64'd5, 64'd0, '1, 1};
      tbl[5]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
      tbl[6]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1,
                  64'h8000_0000_0000_0000, 1};
      tbl[7]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
      tbl[8]  = '{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, '1, 33};
      tbl[9]  = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT32};
      tbl[10] = '{3'd1, 1'b0, '1, '1, 64'd0, MUL_LAT64};
      tbl[11] = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT64};
      tbl[12] = '{3'd2, 1'b0, '1, 64'd2, '1, MUL_LAT64};
      tbl[13] = '{3'd0, 1'b0, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, MUL_LAT64};
      tbl[14] = '{3'd4, 1'b1, 64'h1234_8000_0000, 64'hFFFF_FFFF,
                  64'hFFFF_FFFF_8000_0000, 1};
      tbl[15] = '{3'd7, 1'b1, 64'h1_0000_0007, 64'h5_0000_0000, 64'd7, 1};
      for (int i = 0; i < 16; i++)
         do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].w, tbl[i].a,
               tbl[i].b, tbl[i].r, tbl[i].lat);

      // flush on the 10th CALC cycle: no result, result register untouched
      prev = result;
      op = 3'd5; is_word = 1'b0; src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      chk("calc busy", 64'(busy), 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      chk("flush busy", 64'(busy), 64'd0);
      chk("flush out_valid", 64'(out_valid), 64'd0);
      chk("flush in_ready gated", 64'(in_ready), 64'd0);
      flush = 1'b0;
      #1;
      chk("post flush in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      chk("flush no out_valid", 64'(seen), 64'd0);
      chk("flush result kept", result, prev);

      // flush in DONE beats out_ready and a pending request
      do_op("pre", 3'd6, 1'b0, 64'd9, 64'd4, 64'd1, 65);
      op = 3'd4; is_word = 1'b0; src1 = 64'd5; src2 = 64'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("dz valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1; flush = 1'b1;
      src1 = 64'd77; src2 = 64'd0;
      @(posedge clk); #1;
      chk("done flush", {62'd0, out_valid, busy}, 64'd0);
      chk("done flush result", result, '1);
      flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("no accept under flush", 64'(out_valid), 64'd0);

      // backpressure: 20 cycles in DONE with junk requests offered
      op = 3'd5; is_word = 1'b0; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      chk("bp latency", 64'(n), 64'd65);
      for (int c = 0; c < 20; c++) begin
         in_valid = 1'b1; op = 3'($urandom);
         src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
         @(posedge clk); #1;
         chk($sformatf("bp hold%0d", c),
             {result[61:0], out_valid, in_ready}, {62'd14, 1'b1, 1'b0});
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp release", 64'(out_valid), 64'd0);

      // asynchronous reset mid-CALC
      op = 3'd1; is_word = 1'b0; src1 = 64'd12345; src2 = 64'd678; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst result", result, 64'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 200; i++) begin
         ro = 3'($urandom_range(0, 7));
         rw = 1'($urandom_range(0, 1));
         ra = rnd();
         rb = rnd();
         do_op($sformatf("rand%0d op%0d w%0d %h %h", i, ro, rw, ra, rb),
               ro, rw, ra, rb, model(ro, rw, ra, rb), exp_lat(ro, rw, ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
